line_rd_resp: RTL and testbench

LINE_RD_RESP -- requirements
Module: line_rd_resp

---
 rtl/line_rd_resp.sv | 203 ++++++++++++++++++++
 tb/tb_line_rd_resp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_rd_resp.sv
// -----------------------------------------------------------------------------
// line_rd_resp
//   Serves 32-byte line read requests from a 32-bit word RAM. An accepted
//   request waits WAIT_CYC idle cycles. It then issues eight word reads
//   (idx 0..7) and spends one more cycle capturing the last word. Finally it
//   presents the assembled 256-bit line with a one-cycle dev_rvalid pulse.
//
//   Optional feature (macro LINE_RD_RESP_LINE_BUF_EN):
//   - Compiles in a one-line return buffer: a valid bit plus the 10-bit tag
//     of the last returned line.
//   - A request that hits the buffer goes straight to DONE, re-presenting the
//     held line.
//   - Any mem_wr_evt pulse invalidates the buffer.
//   - Without the macro, every request takes the full path and mem_wr_evt
//     is ignored.
//
// Ports
//   cpu_clk     in   1    clock, rising edge
//   cpu_rst_n   in   1    asynchronous active-low reset
//   cpu_ren     in   4    line read request (any nonzero value)
//   cpu_raddr   in   32   byte address, bits [14:5] select the line
//   dev_rrdy    out  1    request can be accepted (IDLE)
//   dev_rvalid  out  1    one-cycle pulse, dev_rdata valid
//   dev_rdata   out  256  returned line, word i at [32*i+31:32*i]
//   mem_en      out  1    word RAM read enable
//   mem_addr    out  13   word address {line, idx}
//   mem_rdata   in   32   RAM read data, one cycle after mem_en
//   mem_wr_evt  in   1    RAM write pulse (return-buffer invalidation)
// -----------------------------------------------------------------------------
module line_rd_resp #(
    parameter int WAIT_CYC = 2
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst_n,
    input  logic [3:0]   cpu_ren,
    input  logic [31:0]  cpu_raddr,
    output logic         dev_rrdy,
    output logic         dev_rvalid,
    output logic [255:0] dev_rdata,
    output logic         mem_en,
    output logic [12:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_wr_evt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    state_t         state_r;
    logic [9:0]     line_r;
    logic [3:0]     wait_cnt_r;
    logic [3:0]     fetch_cnt_r;
    logic [255:0]   shadow_r;     // words 0..6 collect here; word 7 goes direct to output

    logic           req_s;
    logic [9:0]     req_line_s;
    logic [2:0]     slot_s;
    logic [255:0]   line_data_s;
    logic           hit_s;
    logic           unused_s;

`ifdef LINE_RD_RESP_LINE_BUF_EN
    logic           buf_valid_r;
    logic [9:0]     buf_tag_r;
    logic           wr_seen_r;
    logic           from_fetch_r;
`endif

    // Request decode, capture slot and assembled line.
    always_comb begin
        req_s       = (cpu_ren != 4'd0);
        req_line_s  = cpu_raddr[14:5];
        // Data captured in fetch cycle f belongs to the read issued in cycle f-1.
        slot_s      = fetch_cnt_r[2:0] - 3'd1;
        line_data_s = {mem_rdata, shadow_r[223:0]};
`ifdef LINE_RD_RESP_LINE_BUF_EN
        // A write coincident with accept must force a full fetch.
        if (buf_valid_r && (buf_tag_r == req_line_s) && !mem_wr_evt) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
`else
        hit_s = 1'b0;
`endif
    end

    assign unused_s = ^{cpu_raddr[31:15], cpu_raddr[4:0], mem_wr_evt, shadow_r[255:224]};

    // Main request FSM with registered outputs.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r     <= IDLE;
            line_r      <= 10'd0;
            wait_cnt_r  <= 4'd0;
            fetch_cnt_r <= 4'd0;
            shadow_r    <= 256'd0;
            dev_rrdy    <= 1'b1;
            dev_rvalid  <= 1'b0;
            dev_rdata   <= 256'd0;
            mem_en      <= 1'b0;
            mem_addr    <= 13'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        line_r   <= req_line_s;
                        dev_rrdy <= 1'b0;
                        if (hit_s) begin
                            state_r    <= DONE;
                            dev_rvalid <= 1'b1;
                        end else if (WAIT_LD == 4'd0) begin
                            state_r     <= FETCH;
                            fetch_cnt_r <= 4'd0;
                            mem_en      <= 1'b1;
                            mem_addr    <= {req_line_s, 3'd0};
                        end else begin
                            state_r    <= WAIT;
                            wait_cnt_r <= WAIT_LD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_r <= 4'd1) begin
                        state_r     <= FETCH;
                        wait_cnt_r  <= 4'd0;
                        fetch_cnt_r <= 4'd0;
                        mem_en      <= 1'b1;
                        mem_addr    <= {line_r, 3'd0};
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                FETCH: begin
                    fetch_cnt_r <= fetch_cnt_r + 4'd1;
                    if ((fetch_cnt_r != 4'd0) && (fetch_cnt_r != 4'd8)) begin
                        shadow_r[{slot_s, 5'd0} +: 32] <= mem_rdata;
                    end
                    if (fetch_cnt_r < 4'd7) begin
                        mem_en   <= 1'b1;
                        mem_addr <= {line_r, fetch_cnt_r[2:0] + 3'd1};
                    end else begin
                        mem_en   <= 1'b0;
                        mem_addr <= 13'd0;
                    end
                    if (fetch_cnt_r == 4'd8) begin
                        state_r     <= DONE;
                        fetch_cnt_r <= 4'd0;
                        dev_rvalid  <= 1'b1;
                        dev_rdata   <= line_data_s;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    dev_rvalid <= 1'b0;
                    dev_rrdy   <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    dev_rvalid <= 1'b0;
                    dev_rrdy   <= 1'b1;
                    mem_en     <= 1'b0;
                    mem_addr   <= 13'd0;
                end
            endcase
        end
    end

`ifdef LINE_RD_RESP_LINE_BUF_EN
    // Return buffer: tracks writes during a transaction and holds the tag of the last clean line.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            buf_valid_r  <= 1'b0;
            buf_tag_r    <= 10'd0;
            wr_seen_r    <= 1'b0;
            from_fetch_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && req_s) begin
                wr_seen_r    <= mem_wr_evt;
                from_fetch_r <= !hit_s;
            end else if (state_r != IDLE) begin
                wr_seen_r <= wr_seen_r | mem_wr_evt;
            end else begin
                wr_seen_r <= 1'b0;
            end
            // Any write invalidates; a line fetched while a write occurred is never buffered.
            if (mem_wr_evt) begin
                buf_valid_r <= 1'b0;
            end else if ((state_r == DONE) && from_fetch_r && !wr_seen_r) begin
                buf_valid_r <= 1'b1;
                buf_tag_r   <= line_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_rd_resp.sv
// -----------------------------------------------------------------------------
// tb_line_rd_resp
//   Scoreboard bench for line_rd_resp. Instance u0 (WAIT_CYC=2) is driven by
//   request tasks that push the expected RAM reads and line returns, with
//   their cycles, into queues. A negedge monitor pops those queues and
//   compares them against the DUT. Instance u1 (WAIT_CYC=0) covers the
//   top-line, zero-wait case. Return-buffer hits are predicted only when
//   LINE_RD_RESP_LINE_BUF_EN is defined.
// -----------------------------------------------------------------------------
module tb_line_rd_resp;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } ev_t;

    logic         cpu_clk;
    logic         cpu_rst_n;
    logic [3:0]   cpu_ren;
    logic [31:0]  cpu_raddr;
    logic         dev_rrdy;
    logic         dev_rvalid;
    logic [255:0] dev_rdata;
    logic         mem_en;
    logic [12:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_wr_evt;

    logic [3:0]   ren1;
    logic [31:0]  raddr1;
    logic         rrdy1;
    logic         rvalid1;
    logic [255:0] rdata1;
    logic         men1;
    logic [12:0]  maddr1;
    logic [31:0]  mrd1;
    logic         wr1;

    int           cyc;
    int           n_chk;
    int           n_pass;
    int           n_fail;
    bit           run_mon;
    ev_t          addr_q[$];
    ev_t          resp_q[$];
    ev_t          mon_e;
    logic [255:0] hold_exp;
    bit           mdl_v;
    logic [9:0]   mdl_tag;
    logic [255:0] mdl_data;

    line_rd_resp #(.WAIT_CYC(2)) u0 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
        .dev_rrdy(dev_rrdy), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wr_evt(mem_wr_evt)
    );

    line_rd_resp #(.WAIT_CYC(0)) u1 (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .cpu_ren(ren1), .cpu_raddr(raddr1),
        .dev_rrdy(rrdy1), .dev_rvalid(rvalid1), .dev_rdata(rdata1),
        .mem_en(men1), .mem_addr(maddr1), .mem_rdata(mrd1), .mem_wr_evt(wr1)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Cycle counter: value k during the cycle that follows the k-th rising edge.
    always @(posedge cpu_clk) cyc <= cyc + 1;

    // Word RAM models: word n holds A000_0000+n, one cycle read latency.
    always @(posedge cpu_clk) begin
        if (mem_en) mem_rdata <= 32'hA000_0000 + {19'd0, mem_addr};
        if (men1)   mrd1      <= 32'hA000_0000 + {19'd0, maddr1};
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [255:0] line_of(input logic [9:0] ln);
        logic [255:0] r;
        r = 256'd0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = 32'hA000_0000 + {19'd0, ln, 3'(i)};
        end
        return r;
    endfunction

    // Predicts the outcome of a request accepted at the end of cycle a.
    task automatic push_req(input int a, input logic [9:0] ln, input bit wr_now);
        bit hit;
        hit = 1'b0;
`ifdef LINE_RD_RESP_LINE_BUF_EN
        hit = mdl_v && (mdl_tag == ln) && !wr_now;
`endif
        if (hit) begin
            resp_q.push_back('{cyc: a + 1, data: mdl_data});
        end else begin
            for (int i = 0; i < 8; i++) begin
                addr_q.push_back('{cyc: a + 3 + i, data: 256'({ln, 3'(i)})});
            end
            mdl_data = line_of(ln);
            resp_q.push_back('{cyc: a + 12, data: mdl_data});
            mdl_v   = 1'b1;
            mdl_tag = ln;
        end
        if (wr_now) mdl_v = 1'b0;
    endtask

    // One request; optional mem_wr_evt pulse wr_at cycles after accept (-1: none).
    task automatic do_req(input logic [31:0] addr, input int wr_at);
        int a;
        int n;
        n = 0;
        @(negedge cpu_clk);
        while (!dev_rrdy && n < 40) begin
            @(negedge cpu_clk);
            n++;
        end
        chk("rrdy_before_req", 256'(dev_rrdy), 256'(1'b1));
        cpu_ren    = 4'hF;
        cpu_raddr  = addr;
        mem_wr_evt = (wr_at == 0);
        a = cyc;
        push_req(a, addr[14:5], wr_at == 0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge cpu_clk);
            cpu_ren    = 4'h0;
            mem_wr_evt = (k == wr_at);
        end
        mem_wr_evt = 1'b0;
        if (wr_at >= 0) mdl_v = 1'b0;
    endtask

    // Scoreboard monitor for u0.
    always @(negedge cpu_clk) begin
        if (run_mon) begin
            if (mem_en) begin
                if (addr_q.size() > 0) begin
                    mon_e = addr_q.pop_front();
                    chk("mem_addr", 256'(mem_addr), mon_e.data);
                    chk("mem_en_cycle", 256'(cyc), 256'(mon_e.cyc));
                end else begin
                    chk("stray_mem_en", 256'(mem_en), 256'(1'b0));
                end
            end else begin
                chk("mem_addr_idle", 256'(mem_addr), 256'd0);
            end
            if (dev_rvalid) begin
                if (resp_q.size() > 0) begin
                    mon_e = resp_q.pop_front();
                    chk("rvalid_cycle", 256'(cyc), 256'(mon_e.cyc));
                    hold_exp = mon_e.data;
                end else begin
                    chk("stray_rvalid", 256'(dev_rvalid), 256'(1'b0));
                end
            end
            chk("rdata", dev_rdata, hold_exp);
        end
    end

    initial begin
        int a;
        int n;
        cyc = 0; n_chk = 0; n_pass = 0; n_fail = 0;
        run_mon = 1'b0; hold_exp = 256'd0;
        mdl_v = 1'b0; mdl_tag = 10'd0; mdl_data = 256'd0;
        cpu_rst_n = 1'b0; cpu_ren = 4'h0; cpu_raddr = 32'd0; mem_wr_evt = 1'b0;
        ren1 = 4'h0; raddr1 = 32'd0; wr1 = 1'b0;

        // Reset values
        repeat (3) @(negedge cpu_clk);
        chk("rst_rrdy", 256'(dev_rrdy), 256'(1'b1));
        chk("rst_rvalid", 256'(dev_rvalid), 256'(1'b0));
        chk("rst_mem_en", 256'(mem_en), 256'(1'b0));
        chk("rst_mem_addr", 256'(mem_addr), 256'd0);
        chk("rst_rdata", dev_rdata, 256'd0);
        #2 cpu_rst_n = 1'b1;
        run_mon = 1'b1;

        // Basic line, same-line repeat (buffer hit when enabled), stray bits ignored
        do_req(32'h0000_0040, -1);
        do_req(32'h0000_005C, -1);
        @(negedge cpu_clk); mem_wr_evt = 1'b1; mdl_v = 1'b0;
        @(negedge cpu_clk); mem_wr_evt = 1'b0;
        do_req(32'h0000_005C, -1);
        do_req(32'h0000_0060, -1);
        do_req(32'h0000_0040, 5);
        do_req(32'h0000_0040, -1);
        do_req(32'h0000_0040, 0);
        do_req(32'hFFFF_805F, -1);
        do_req(32'hDEAD_BEEF, -1);

        // Request held high: one accept per IDLE visit
        n = 0;
        @(negedge cpu_clk);
        while (!dev_rrdy && n < 40) begin @(negedge cpu_clk); n++; end
        cpu_ren = 4'hF; cpu_raddr = 32'h0000_0080;
        a = cyc;
        push_req(a, 10'd4, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge cpu_clk);
            chk("held_rrdy", 256'(dev_rrdy), 256'(k == 13));
        end
        push_req(a + 13, 10'd4, 1'b0);
        for (int k = 14; k <= 28; k++) begin
            @(negedge cpu_clk);
            cpu_ren = 4'h0;
        end

        // Zero-wait instance, top line
        @(negedge cpu_clk);
        chk("u1_rrdy", 256'(rrdy1), 256'(1'b1));
        ren1 = 4'hF; raddr1 = 32'h0000_7FFF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge cpu_clk);
            ren1 = 4'h0;
            chk("u1_mem_en", 256'(men1), 256'((k >= 1) && (k <= 8)));
            chk("u1_mem_addr", 256'(maddr1), (k <= 8) ? 256'(8184 + k - 1) : 256'd0);
            chk("u1_rvalid", 256'(rvalid1), 256'(k == 10));
            if (k == 10) chk("u1_rdata", rdata1, line_of(10'd1023));
        end

        // Reset in cycle 6 of a transaction
        @(negedge cpu_clk);
        cpu_ren = 4'hF; cpu_raddr = 32'h0000_0100;
        push_req(cyc, 10'd8, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge cpu_clk);
            cpu_ren = 4'h0;
        end
        #2 cpu_rst_n = 1'b0;
        addr_q.delete(); resp_q.delete();
        hold_exp = 256'd0; mdl_v = 1'b0;
        #1;
        chk("midrst_rrdy", 256'(dev_rrdy), 256'(1'b1));
        chk("midrst_rvalid", 256'(dev_rvalid), 256'(1'b0));
        chk("midrst_mem_en", 256'(mem_en), 256'(1'b0));
        chk("midrst_mem_addr", 256'(mem_addr), 256'd0);
        chk("midrst_rdata", dev_rdata, 256'd0);
        repeat (2) @(negedge cpu_clk);
        #2 cpu_rst_n = 1'b1;
        do_req(32'h0000_0100, -1);

        repeat (3) @(negedge cpu_clk);
        chk("pending_addr", 256'(addr_q.size()), 256'd0);
        chk("pending_resp", 256'(resp_q.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
